ifetch_ctrl: RTL and testbench

//  Fetch-side controller that drives the PC register's pc_en/pc_load/pc_in and consumes its pc_out.

---
 rtl/ifetch_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_ifetch_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl
// Fetch-side controller between the PC register, instruction memory and decode.
// Issues in-order fetch requests at pc_out, tracks in-flight fetches, buffers
// returned words in a DEPTH-entry queue, applies redirects and discards stale
// responses that were in flight when a redirect happened.
//
// Parameters: DEPTH (queue entries / max outstanding+buffered, power of 2, >=2),
//             XLEN  (address/instruction width).
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   pc_out                   current PC from PC register
//   pc_en, pc_load, pc_in    PC register advance / load-select / load value
//   redirect_valid/_pc       branch-unit redirect strobe and target
//   imem_req_valid/_ready/_addr   fetch request channel
//   imem_rsp_valid/_data     in-order response channel (never stalled)
//   inst_valid/_ready/_data/_pc   instruction channel to decode
//
// Build option: define IFETCH_BYPASS_EN to forward a kept response straight to
// decode in its arrival cycle when the queue is empty.

module ifetch_ctrl #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_out,
    output logic            pc_en,
    output logic            pc_load,
    output logic [XLEN-1:0] pc_in,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [CW-1:0]   live_cnt_q, live_cnt_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]   q_cnt_q, q_cnt_d;
    logic [PW-1:0]   q_rd_ptr_q, q_rd_ptr_d;
    logic [PW-1:0]   q_wr_ptr_q, q_wr_ptr_d;
    logic [PW-1:0]   f_rd_ptr_q, f_rd_ptr_d;
    logic [PW-1:0]   f_wr_ptr_q, f_wr_ptr_d;
    logic [XLEN-1:0] q_data_mem_q [DEPTH];
    logic [XLEN-1:0] q_data_mem_d [DEPTH];
    logic [XLEN-1:0] q_pc_mem_q   [DEPTH];
    logic [XLEN-1:0] q_pc_mem_d   [DEPTH];
    logic [XLEN-1:0] f_pc_mem_q   [DEPTH];
    logic [XLEN-1:0] f_pc_mem_d   [DEPTH];

    logic            credit_ok;
    logic            req_fire;
    logic            rsp_keep;
    logic            rsp_drop;
    logic            bypass_vld;
    logic            inst_valid_int;
    logic [XLEN-1:0] inst_data_int;
    logic [XLEN-1:0] inst_pc_int;
    logic            q_push;
    logic            q_pop;

    // Every slot is either in flight (kept or to be dropped) or buffered,
    // so this sum never exceeds DEPTH and the queue cannot overflow.
    always_comb begin
        credit_ok = ({2'b00, live_cnt_q} + {2'b00, drop_cnt_q} + {2'b00, q_cnt_q})
                    < (CW + 2)'(DEPTH);
    end

    always_comb begin
        req_fire = credit_ok & ~redirect_valid & imem_req_ready;
        rsp_keep = imem_rsp_valid & (drop_cnt_q == '0) & ~redirect_valid;
        rsp_drop = imem_rsp_valid & (drop_cnt_q != '0) & ~redirect_valid;
`ifdef IFETCH_BYPASS_EN
        bypass_vld = rsp_keep & (q_cnt_q == '0);
`else
        bypass_vld = 1'b0;
`endif
        inst_valid_int = ((q_cnt_q != '0) & ~redirect_valid) | bypass_vld;
        inst_data_int  = bypass_vld ? imem_rsp_data : q_data_mem_q[q_rd_ptr_q];
        inst_pc_int    = bypass_vld ? f_pc_mem_q[f_rd_ptr_q] : q_pc_mem_q[q_rd_ptr_q];
        // A bypassed word consumed by decode never touches the queue.
        q_pop  = inst_valid_int & inst_ready & ~bypass_vld;
        q_push = rsp_keep & ~(bypass_vld & inst_ready);
    end

    always_comb begin
        live_cnt_d   = live_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        q_cnt_d      = q_cnt_q;
        q_rd_ptr_d   = q_rd_ptr_q;
        q_wr_ptr_d   = q_wr_ptr_q;
        f_rd_ptr_d   = f_rd_ptr_q;
        f_wr_ptr_d   = f_wr_ptr_q;
        q_data_mem_d = q_data_mem_q;
        q_pc_mem_d   = q_pc_mem_q;
        f_pc_mem_d   = f_pc_mem_q;

        if (redirect_valid) begin
            // Everything kept so far becomes stale; a response arriving this
            // cycle retires one of those stale fetches immediately.
            drop_cnt_d = drop_cnt_q + live_cnt_q - CW'(imem_rsp_valid);
            live_cnt_d = '0;
            q_cnt_d    = '0;
            q_rd_ptr_d = '0;
            q_wr_ptr_d = '0;
            f_rd_ptr_d = '0;
            f_wr_ptr_d = '0;
        end else begin
            if (req_fire) begin
                f_pc_mem_d[f_wr_ptr_q] = pc_out;
                f_wr_ptr_d             = f_wr_ptr_q + PTR_ONE;
            end
            if (rsp_drop) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
            if (rsp_keep) begin
                f_rd_ptr_d = f_rd_ptr_q + PTR_ONE;
            end
            if (q_push) begin
                q_data_mem_d[q_wr_ptr_q] = imem_rsp_data;
                q_pc_mem_d[q_wr_ptr_q]   = f_pc_mem_q[f_rd_ptr_q];
                q_wr_ptr_d               = q_wr_ptr_q + PTR_ONE;
            end
            if (q_pop) begin
                q_rd_ptr_d = q_rd_ptr_q + PTR_ONE;
            end
            live_cnt_d = live_cnt_q + CW'(req_fire) - CW'(rsp_keep);
            q_cnt_d    = q_cnt_q + CW'(q_push) - CW'(q_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_cnt_q   <= '0;
            drop_cnt_q   <= '0;
            q_cnt_q      <= '0;
            q_rd_ptr_q   <= '0;
            q_wr_ptr_q   <= '0;
            f_rd_ptr_q   <= '0;
            f_wr_ptr_q   <= '0;
            q_data_mem_q <= '{default: '0};
            q_pc_mem_q   <= '{default: '0};
            f_pc_mem_q   <= '{default: '0};
        end else begin
            live_cnt_q   <= live_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            q_cnt_q      <= q_cnt_d;
            q_rd_ptr_q   <= q_rd_ptr_d;
            q_wr_ptr_q   <= q_wr_ptr_d;
            f_rd_ptr_q   <= f_rd_ptr_d;
            f_wr_ptr_q   <= f_wr_ptr_d;
            q_data_mem_q <= q_data_mem_d;
            q_pc_mem_q   <= q_pc_mem_d;
            f_pc_mem_q   <= f_pc_mem_d;
        end
    end

    // All outputs are forced low while reset is held.
    always_comb begin
        imem_req_valid = ~rst & credit_ok & ~redirect_valid;
        imem_req_addr  = rst ? '0 : pc_out;
        pc_en          = ~rst & (req_fire | redirect_valid);
        pc_load        = ~rst & redirect_valid;
        pc_in          = (~rst & redirect_valid) ? redirect_pc : '0;
        inst_valid     = ~rst & inst_valid_int;
        inst_data      = rst ? '0 : inst_data_int;
        inst_pc        = rst ? '0 : inst_pc_int;
    end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: models the PC register and an in-order memory with
// random latency, and predicts every output from a transaction-level view
// (list of in-flight fetches tagged stale/kept, list of buffered words).

module tb_ifetch_ctrl;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned XLEN  = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [XLEN-1:0] pc_out;
    logic            pc_en;
    logic            pc_load;
    logic [XLEN-1:0] pc_in;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst_data;
    logic [XLEN-1:0] inst_pc;

    ifetch_ctrl #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .pc_out(pc_out),
        .pc_en(pc_en), .pc_load(pc_load), .pc_in(pc_in),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        int          due;
        bit          stale;
    } fetch_t;

    fetch_t      mem_q[$];
    logic [31:0] buf_q[$];
    logic [31:0] pc_reg;
    int          cyc;
    int          last_due;
    bit          last_red;
    int          compared;
    int          mismatched;

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return {pc[15:0] ^ 16'h5A3C, pc[31:16] ^ 16'hC3E1};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            rst            = 1'b1;
            redirect_valid = 1'($urandom_range(1));
            redirect_pc    = $urandom();
            imem_req_ready = 1'b1;
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom();
            inst_ready     = 1'b1;
            pc_out         = 32'h1000;
            #1;
            chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
            chk("rst_req_addr", imem_req_addr, 32'h0);
            chk("rst_pc_en", 32'(pc_en), 32'h0);
            chk("rst_pc_load", 32'(pc_load), 32'h0);
            chk("rst_pc_in", pc_in, 32'h0);
            chk("rst_inst_valid", 32'(inst_valid), 32'h0);
            chk("rst_inst_data", inst_data, 32'h0);
            chk("rst_inst_pc", inst_pc, 32'h0);
        end
        mem_q.delete();
        buf_q.delete();
        pc_reg   = 32'h1000;
        last_due = cyc;
        last_red = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic cycle_step(input int p_rr, input int p_ir, input int p_red, input int max_lat);
        bit          red, rsp, exp_rv, accept, keep, byp, exp_iv;
        logic [31:0] rpc, exp_pc;
        int          due;
        fetch_t      e;

        @(negedge clk);
        cyc++;
        imem_req_ready = ($urandom_range(99) < p_rr);
        inst_ready     = ($urandom_range(99) < p_ir);
        red            = !last_red && ($urandom_range(99) < p_red);
        case ($urandom_range(3))
            0:       rpc = 32'h2000;
            1:       rpc = 32'hFFFF_FFF8;
            default: rpc = $urandom() & 32'hFFFF_FFFC;
        endcase
        redirect_valid = red;
        redirect_pc    = red ? rpc : $urandom();
        rsp            = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? word_of(mem_q[0].pc) : $urandom();
        pc_out         = pc_reg;
        #1;

        exp_rv = ((mem_q.size() + buf_q.size()) < DEPTH) && !red;
        accept = exp_rv && imem_req_ready;
        keep   = rsp && !mem_q[0].stale && !red;
        byp    = 1'b0;
`ifdef IFETCH_BYPASS_EN
        byp    = keep && (buf_q.size() == 0);
`endif
        exp_iv = ((buf_q.size() > 0) && !red) || byp;

        chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        chk("req_addr", imem_req_addr, pc_reg);
        chk("pc_en", 32'(pc_en), 32'(accept || red));
        chk("pc_load", 32'(pc_load), 32'(red));
        chk("pc_in", pc_in, red ? rpc : 32'h0);
        chk("inst_valid", 32'(inst_valid), 32'(exp_iv));
        if (exp_iv) begin
            exp_pc = byp ? mem_q[0].pc : buf_q[0];
            chk("inst_pc", inst_pc, exp_pc);
            chk("inst_data", inst_data, word_of(exp_pc));
        end

        if (red) begin
            foreach (mem_q[i]) mem_q[i].stale = 1'b1;
            if (rsp) void'(mem_q.pop_front());
            buf_q.delete();
            pc_reg = rpc;
        end else begin
            if (exp_iv && inst_ready && !byp) void'(buf_q.pop_front());
            if (rsp) begin
                e = mem_q.pop_front();
                if (keep && !(byp && inst_ready)) buf_q.push_back(e.pc);
            end
            if (accept) begin
                due = cyc + $urandom_range(max_lat, 1);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mem_q.push_back('{pc: pc_reg, due: due, stale: 1'b0});
                pc_reg = pc_reg + 32'd4;
            end
        end
        last_red = red;
    endtask

    initial begin
        compared       = 0;
        mismatched     = 0;
        cyc            = 0;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        inst_ready     = 1'b0;
        pc_out         = 32'h1000;

        do_reset(3);
        // Sequential fetch, 1-cycle memory, decode always ready.
        for (int i = 0; i < 20; i++) cycle_step(100, 100, 0, 1);
        // Decode stalled: credits fill, requests stop; then released.
        for (int i = 0; i < 12; i++) cycle_step(100, 0, 0, 1);
        for (int i = 0; i < 10; i++) cycle_step(100, 100, 0, 1);
        // Frequent redirects with multi-cycle memory latency.
        for (int i = 0; i < 40; i++) cycle_step(100, 70, 25, 3);
        // Memory refuses requests for a while.
        for (int i = 0; i < 5; i++)  cycle_step(0, 100, 0, 1);
        for (int i = 0; i < 10; i++) cycle_step(100, 100, 0, 2);
        // Fully random traffic.
        for (int i = 0; i < 400; i++) cycle_step(70, 60, 8, 4);
        // Reset in the middle of traffic.
        do_reset(2);
        for (int i = 0; i < 150; i++) cycle_step(80, 70, 10, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
